// File: rtl/tree_mac_scheduler.sv
// rtl/tree_mac_scheduler.sv - credit-based issue scheduler feeding a pipelined tree adder
//
// Purpose: walks an I x K index space (k fastest) and issues one operand
// vector per cycle to a tree adder. The scheduler stalls when the downstream
// result buffer has no free slots. A job completes once every issued result
// has come back from the adder.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   cfg_val/cfg_rdy      job handshake (cfg_rdy only in IDLE)
//   cfg_num_i/cfg_num_k  job dimensions
//   src_val/src_rdy      operand availability / consumption (src_rdy == issue_val)
//   issue_val/addr_i/k   issue strobe and index pair to the adder
//   res_val              adder result strobe (in-flight count decrements)
//   res_deq              downstream buffer dequeue (returns one credit)
//   done                 one-cycle completion pulse
//   err                  sticky protocol error, cleared when a job is accepted
module tree_mac_scheduler #(
  parameter int ADDRESS_WIDTH_I = 8,
  parameter int ADDRESS_WIDTH_K = 8,
  parameter int CREDITS         = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_val,
  output logic                       cfg_rdy,
  input  logic [ADDRESS_WIDTH_I-1:0] cfg_num_i,
  input  logic [ADDRESS_WIDTH_K-1:0] cfg_num_k,
  input  logic                       src_val,
  output logic                       src_rdy,
  output logic                       issue_val,
  output logic [ADDRESS_WIDTH_I-1:0] issue_addr_i,
  output logic [ADDRESS_WIDTH_K-1:0] issue_addr_k,
  input  logic                       res_val,
  input  logic                       res_deq,
  output logic                       done,
  output logic                       err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                     state, state_next;
  logic [ADDRESS_WIDTH_I-1:0] num_i, cnt_i;
  logic [ADDRESS_WIDTH_K-1:0] num_k, cnt_k;
  logic [CW-1:0]              credits, in_flight;

  logic accept, issue, last_i, last_k, err_set;

  assign accept  = cfg_val && (state == IDLE);
  assign issue   = (state == RUN) && src_val && (credits != '0);
  assign last_i  = (cnt_i == num_i - ADDRESS_WIDTH_I'(1));
  assign last_k  = (cnt_k == num_k - ADDRESS_WIDTH_K'(1));
  // A returned credit is legitimate when an issue consumes one in the same
  // cycle, even if the counter is already full.
  assign err_set = (res_val && (in_flight == '0)) ||
                   (res_deq && !issue && (credits == CRED_MAX));

  always_comb begin
    state_next   = state;
    cfg_rdy      = 1'b0;
    done         = 1'b0;
    issue_val    = issue;
    src_rdy      = issue;
    issue_addr_i = cnt_i;
    issue_addr_k = cnt_k;
    case (state)
      IDLE: begin
        cfg_rdy = 1'b1;
        if (cfg_val) begin
          if ((cfg_num_i == '0) || (cfg_num_k == '0)) state_next = DONE;
          else                                        state_next = RUN;
        end
      end
      RUN: begin
        if (issue && last_i && last_k) state_next = DRAIN;
      end
      DRAIN: begin
        // Leave as soon as the final result lands, not one cycle later.
        if ((in_flight == '0) || ((in_flight == CW'(1)) && res_val))
          state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      num_i     <= '0;
      num_k     <= '0;
      cnt_i     <= '0;
      cnt_k     <= '0;
      credits   <= CRED_MAX;
      in_flight <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_next;

      if (accept) begin
        num_i <= cfg_num_i;
        num_k <= cfg_num_k;
        cnt_i <= '0;
        cnt_k <= '0;
      end else if (issue) begin
        if (last_k) begin
          cnt_k <= '0;
          cnt_i <= cnt_i + ADDRESS_WIDTH_I'(1);
        end else begin
          cnt_k <= cnt_k + ADDRESS_WIDTH_K'(1);
        end
      end

      case ({issue, res_deq})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   if (credits != CRED_MAX) credits <= credits + CW'(1);
        default: credits <= credits;
      endcase

      case ({issue, res_val})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   if (in_flight != '0) in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase

      if (err_set)     err <= 1'b1;
      else if (accept) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tree_mac_scheduler.sv
// tb/tb_tree_mac_scheduler.sv - scoreboard bench for tree_mac_scheduler
module tb_tree_mac_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_val;
  logic       cfg_rdy;
  logic [7:0] cfg_num_i, cfg_num_k;
  logic       src_val, src_rdy, issue_val;
  logic [7:0] issue_addr_i, issue_addr_k;
  logic       res_val, res_deq, done, err;

  // Adder / buffer model controls
  logic       auto_res, auto_deq, res_force, deq_force;
  logic [4:0] lat_sr = '0;
  logic       deq_sr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int issue_count = 0;
  int exp_done_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  tree_mac_scheduler #(.ADDRESS_WIDTH_I(8), .ADDRESS_WIDTH_K(8), .CREDITS(4)) dut (
    .clk(clk), .reset(reset),
    .cfg_val(cfg_val), .cfg_rdy(cfg_rdy), .cfg_num_i(cfg_num_i), .cfg_num_k(cfg_num_k),
    .src_val(src_val), .src_rdy(src_rdy), .issue_val(issue_val),
    .issue_addr_i(issue_addr_i), .issue_addr_k(issue_addr_k),
    .res_val(res_val), .res_deq(res_deq), .done(done), .err(err)
  );

  // Five-cycle adder latency; the buffer dequeues one cycle after each result.
  assign res_val = (auto_res && lat_sr[4]) || res_force;
  assign res_deq = (auto_deq && deq_sr) || deq_force;

  always @(posedge clk) begin
    if (!reset) begin
      lat_sr <= '0;
      deq_sr <= 1'b0;
    end else begin
      lat_sr <= {lat_sr[3:0], issue_val};
      deq_sr <= res_val;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every issue is matched against the next expected address pair,
  // every done pulse against an outstanding expected completion.
  always @(negedge clk) begin
    if (reset) begin
      if (issue_val) begin
        logic [15:0] e;
        issue_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("issue_addr", 32'({issue_addr_i, issue_addr_k}), 32'(e));
          check("src_rdy_eq_issue", 32'(src_rdy), 32'(1));
        end
      end
      if (done) begin
        check("done_expected", 32'(exp_done_cnt > 0), 32'(1));
        if (exp_done_cnt > 0) exp_done_cnt--;
      end
    end
  end

  task automatic push_job(input int ni, input int nk);
    for (int i = 0; i < ni; i++)
      for (int k = 0; k < nk; k++)
        exp_q.push_back({8'(i), 8'(k)});
  endtask

  task automatic start_job(input logic [7:0] ni, input logic [7:0] nk);
    cfg_num_i = ni;
    cfg_num_k = nk;
    cfg_val   = 1'b1;
    @(negedge clk);
    cfg_val   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check(name, 32'(got), 32'(1));
  endtask

  task automatic deq_pulse();
    deq_force = 1'b1;
    @(negedge clk);
    deq_force = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b0; cfg_val = 1'b0; cfg_num_i = '0; cfg_num_k = '0; src_val = 1'b0;
    auto_res = 1'b0; auto_deq = 1'b0; res_force = 1'b0; deq_force = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_cfg_rdy",   32'(cfg_rdy), 32'(1));
    check("rst_issue_val", 32'(issue_val), 32'(0));
    check("rst_src_rdy",   32'(src_rdy), 32'(0));
    check("rst_done",      32'(done), 32'(0));
    check("rst_err",       32'(err), 32'(0));
    check("rst_addr",      32'({issue_addr_i, issue_addr_k}), 32'(0));
    check("rst_credits",   32'(dut.credits), 32'(4));
    reset = 1'b1;
    @(negedge clk);

    // Basic 2x3 job, continuous operands, latency-5 adder, auto dequeue
    auto_res = 1'b1; auto_deq = 1'b1; src_val = 1'b1;
    push_job(2, 3);
    exp_done_cnt++;
    base = issue_count;
    start_job(8'd2, 8'd3);
    wait_done("basic_done");
    check("basic_issues", 32'(issue_count - base), 32'(6));
    check("basic_err", 32'(err), 32'(0));
    @(negedge clk);
    check("basic_done_one_cycle", 32'(done), 32'(0));
    check("basic_cfg_rdy", 32'(cfg_rdy), 32'(1));
    repeat (3) @(negedge clk);
    check("basic_credits_back", 32'(dut.credits), 32'(4));

    // Credit stall: 1x8 job with no dequeue
    auto_deq = 1'b0;
    push_job(1, 8);
    exp_done_cnt++;
    base = issue_count;
    start_job(8'd1, 8'd8);
    repeat (12) @(negedge clk);
    check("stall_issues", 32'(issue_count - base), 32'(4));
    check("stall_issue_val", 32'(issue_val), 32'(0));
    check("stall_credits", 32'(dut.credits), 32'(0));
    for (int n = 0; n < 4; n++) begin
      deq_pulse();
      repeat (2) @(negedge clk);
      check("stall_one_more", 32'(issue_count - base), 32'(5 + n));
    end
    wait_done("stall_done");
    for (int n = 0; n < 4; n++) deq_pulse();
    check("stall_credits_restored", 32'(dut.credits), 32'(4));
    check("stall_err", 32'(err), 32'(0));

    // Simultaneous events on a 1x3 job with a manually driven adder
    auto_res = 1'b0; src_val = 1'b0;
    push_job(1, 3);
    exp_done_cnt++;
    start_job(8'd1, 8'd3);
    src_val = 1'b1;
    @(negedge clk);
    check("sim_credits_a", 32'(dut.credits), 32'(3));
    check("sim_inflight_a", 32'(dut.in_flight), 32'(1));
    deq_force = 1'b1; res_force = 1'b1;
    @(negedge clk);
    check("sim_credits_issue_deq", 32'(dut.credits), 32'(3));
    check("sim_inflight_issue_res", 32'(dut.in_flight), 32'(1));
    deq_force = 1'b0; res_force = 1'b0;
    @(negedge clk);
    src_val = 1'b0;
    check("sim_credits_b", 32'(dut.credits), 32'(2));
    check("sim_inflight_b", 32'(dut.in_flight), 32'(2));
    deq_force = 1'b1; res_force = 1'b1;
    @(negedge clk);
    check("sim_drain_no_done", 32'(done), 32'(0));
    @(negedge clk);
    deq_force = 1'b0; res_force = 1'b0;
    check("sim_done_on_last_res", 32'(done), 32'(1));
    check("sim_credits_c", 32'(dut.credits), 32'(4));
    check("sim_err", 32'(err), 32'(0));
    @(negedge clk);

    // Empty job: zero column count
    exp_done_cnt++;
    src_val = 1'b1;
    base = issue_count;
    start_job(8'd3, 8'd0);
    check("empty_done", 32'(done), 32'(1));
    check("empty_issue_val", 32'(issue_val), 32'(0));
    @(negedge clk);
    check("empty_done_cleared", 32'(done), 32'(0));
    check("empty_cfg_rdy", 32'(cfg_rdy), 32'(1));
    check("empty_no_issues", 32'(issue_count - base), 32'(0));
    src_val = 1'b0;

    // Reset in the middle of a job after three issues
    auto_res = 1'b1; auto_deq = 1'b1;
    push_job(1, 3);
    base = issue_count;
    start_job(8'd2, 8'd3);
    src_val = 1'b1;
    repeat (3) @(negedge clk);
    src_val = 1'b0;
    check("midrst_issues", 32'(issue_count - base), 32'(3));
    reset = 1'b0;
    @(negedge clk);
    check("midrst_cfg_rdy", 32'(cfg_rdy), 32'(1));
    check("midrst_credits", 32'(dut.credits), 32'(4));
    check("midrst_inflight", 32'(dut.in_flight), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_more_issues", 32'(issue_count - base), 32'(3));
    check("midrst_err", 32'(err), 32'(0));

    // Error flag: result with nothing in flight
    res_force = 1'b1;
    @(negedge clk);
    res_force = 1'b0;
    check("err_set", 32'(err), 32'(1));
    check("err_credits_kept", 32'(dut.credits), 32'(4));
    check("err_inflight_kept", 32'(dut.in_flight), 32'(0));
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err), 32'(1));
    exp_done_cnt++;
    start_job(8'd0, 8'd2);
    check("err_cleared_on_accept", 32'(err), 32'(0));
    check("err_job_done", 32'(done), 32'(1));
    repeat (2) @(negedge clk);

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    check("all_done_seen", 32'(exp_done_cnt), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
